// File: rtl/vdp_cpu_port_if.sv
// CPU-side bus of the VDP: CPU strobes and read data plus the VRAM, CRAM and
// register-file ports. The master drives strobes and memory read data.
interface vdp_cpu_port_if;
  logic        ctrl_wr;
  logic        ctrl_rd;
  logic        data_wr;
  logic        data_rd;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do;
  logic [7:0]  status_in;
  logic        status_ack;
  logic        busy;
  logic [13:0] vram_a;
  logic        vram_re;
  logic [7:0]  vram_q;
  logic        vram_we;
  logic [7:0]  vram_d;
  logic [5:0]  cram_a;
  logic        cram_we;
  logic [7:0]  cram_d;
  logic        reg_we;
  logic [3:0]  reg_a;
  logic [7:0]  reg_d;

  modport master (
    output ctrl_wr, ctrl_rd, data_wr, data_rd, cpu_di, status_in, vram_q,
    input  cpu_do, status_ack, busy, vram_a, vram_re, vram_we, vram_d,
           cram_a, cram_we, cram_d, reg_we, reg_a, reg_d
  );

  modport slave (
    input  ctrl_wr, ctrl_rd, data_wr, data_rd, cpu_di, status_in, vram_q,
    output cpu_do, status_ack, busy, vram_a, vram_re, vram_we, vram_d,
           cram_a, cram_we, cram_d, reg_we, reg_a, reg_d
  );
endinterface

// File: rtl/vdp_cpu_port.sv
// VDP CPU port: two-byte control writes set address/code, data port accesses
// go to VRAM or CRAM, and data reads are served from a one-byte prefetch buffer.
module vdp_cpu_port (
  input  logic          clk,
  input  logic          rst_n,
  vdp_cpu_port_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA} state_t;

  state_t      state_reg, state_next;
  logic [13:0] addr_reg;
  logic [1:0]  code_reg;
  logic        flag_reg;
  logic [7:0]  read_buf_reg;
  logic [7:0]  cpu_do_reg;
  logic        status_ack_reg;
  logic [13:0] vram_a_reg;
  logic        vram_we_reg;
  logic [7:0]  vram_d_reg;
  logic [5:0]  cram_a_reg;
  logic        cram_we_reg;
  logic [7:0]  cram_d_reg;
  logic        reg_we_reg;
  logic [3:0]  reg_a_reg;
  logic [7:0]  reg_d_reg;

  logic        idle;
  logic        start_read;
  logic [13:0] addr_inc;
  logic [13:0] read_addr;

  assign idle     = (state_reg == IDLE);
  assign addr_inc = addr_reg + 14'd1;
  // A prefetch starts either from a second control byte with code 0 or from a data read.
  assign start_read = idle && ((bus.ctrl_wr && flag_reg && (bus.cpu_di[7:6] == 2'd0))
                               || bus.data_rd);
  assign read_addr  = bus.ctrl_wr ? {bus.cpu_di[5:0], addr_reg[7:0]} : addr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_read) state_next = RD_ADDR;
      RD_ADDR: state_next = RD_DATA;
      RD_DATA: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg       <= '0;
      code_reg       <= '0;
      flag_reg       <= 1'b0;
      read_buf_reg   <= '0;
      cpu_do_reg     <= '0;
      status_ack_reg <= 1'b0;
      vram_a_reg     <= '0;
      vram_we_reg    <= 1'b0;
      vram_d_reg     <= '0;
      cram_a_reg     <= '0;
      cram_we_reg    <= 1'b0;
      cram_d_reg     <= '0;
      reg_we_reg     <= 1'b0;
      reg_a_reg      <= '0;
      reg_d_reg      <= '0;
    end else begin
      vram_we_reg    <= 1'b0;
      cram_we_reg    <= 1'b0;
      reg_we_reg     <= 1'b0;
      status_ack_reg <= 1'b0;
      if (state_reg == RD_DATA) begin
        read_buf_reg <= bus.vram_q;
        addr_reg     <= addr_inc;
      end else if (idle) begin
        if (bus.ctrl_wr) begin
          if (!flag_reg) begin
            addr_reg[7:0] <= bus.cpu_di;
            flag_reg      <= 1'b1;
          end else begin
            addr_reg[13:8] <= bus.cpu_di[5:0];
            code_reg       <= bus.cpu_di[7:6];
            flag_reg       <= 1'b0;
            // Register writes reuse the first control byte as the data value.
            if (bus.cpu_di[7:6] == 2'd2) begin
              reg_we_reg <= 1'b1;
              reg_a_reg  <= bus.cpu_di[3:0];
              reg_d_reg  <= addr_reg[7:0];
            end
          end
        end else if (bus.data_wr) begin
          flag_reg     <= 1'b0;
          read_buf_reg <= bus.cpu_di;
          addr_reg     <= addr_inc;
          if (code_reg == 2'd3) begin
            cram_we_reg <= 1'b1;
            cram_a_reg  <= addr_reg[5:0];
            cram_d_reg  <= bus.cpu_di;
          end else begin
            vram_we_reg <= 1'b1;
            vram_a_reg  <= addr_reg;
            vram_d_reg  <= bus.cpu_di;
          end
        end else if (bus.data_rd) begin
          flag_reg   <= 1'b0;
          cpu_do_reg <= read_buf_reg;
        end else if (bus.ctrl_rd) begin
          flag_reg       <= 1'b0;
          cpu_do_reg     <= bus.status_in;
          status_ack_reg <= 1'b1;
        end
        if (start_read) vram_a_reg <= read_addr;
      end
    end
  end

  assign bus.busy       = !idle;
  assign bus.vram_re    = (state_reg == RD_ADDR);
  assign bus.cpu_do     = cpu_do_reg;
  assign bus.status_ack = status_ack_reg;
  assign bus.vram_a     = vram_a_reg;
  assign bus.vram_we    = vram_we_reg;
  assign bus.vram_d     = vram_d_reg;
  assign bus.cram_a     = cram_a_reg;
  assign bus.cram_we    = cram_we_reg;
  assign bus.cram_d     = cram_d_reg;
  assign bus.reg_we     = reg_we_reg;
  assign bus.reg_a      = reg_a_reg;
  assign bus.reg_d      = reg_d_reg;
endmodule

// File: tb/tb_vdp_cpu_port.sv
// Bench for vdp_cpu_port: directed scenarios then random CPU operations,
// checked against a byte-level model of address, code, buffer and VRAM contents.
module tb_vdp_cpu_port;
  localparam int K_CW = 0;
  localparam int K_CR = 1;
  localparam int K_DW = 2;
  localparam int K_DR = 3;

  logic clk = 1'b0;
  logic rst_n;
  vdp_cpu_port_if bus ();

  vdp_cpu_port dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         m_addr;
  logic [1:0] m_code;
  bit         m_second;
  logic [7:0] m_rbuf;
  logic [7:0] m_cpu_do;
  logic [7:0] ref_mem [16384];
  logic [7:0] vram_mem [16384];

  function automatic logic [7:0] init_byte(input int i);
    if (i == 256) return 8'h11;
    if (i == 257) return 8'h22;
    return 8'((i * 37 + 11) ^ (i >> 6));
  endfunction

  // Behavioural VRAM: read data appears the cycle after vram_re.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16384; i++) vram_mem[i] <= init_byte(i);
      bus.vram_q <= 8'h00;
    end else begin
      if (bus.vram_we) vram_mem[bus.vram_a] <= bus.vram_d;
      if (bus.vram_re) bus.vram_q <= vram_mem[bus.vram_a];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = 0;
    m_code = 2'd0;
    m_second = 1'b0;
    m_rbuf = 8'h00;
    m_cpu_do = 8'h00;
    for (int i = 0; i < 16384; i++) ref_mem[i] = init_byte(i);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One-cycle strobe; returns at the negedge following the accepting edge.
  task automatic strobe(input int kind, input logic [7:0] val);
    @(negedge clk);
    bus.cpu_di    = val;
    bus.status_in = val;
    bus.ctrl_wr   = (kind == K_CW);
    bus.ctrl_rd   = (kind == K_CR);
    bus.data_wr   = (kind == K_DW);
    bus.data_rd   = (kind == K_DR);
    @(negedge clk);
    bus.ctrl_wr = 1'b0;
    bus.ctrl_rd = 1'b0;
    bus.data_wr = 1'b0;
    bus.data_rd = 1'b0;
  endtask

  task automatic do_op(input int kind, input logic [7:0] val);
    logic       exp_vw, exp_cw, exp_rw, exp_sa, exp_pf;
    logic [13:0] exp_va;
    logic [5:0] exp_ca;
    logic [3:0] exp_ra;
    logic [7:0] exp_rd;
    int         pf_addr;
    exp_vw = 0; exp_cw = 0; exp_rw = 0; exp_sa = 0; exp_pf = 0;
    exp_va = '0; exp_ca = '0; exp_ra = '0; exp_rd = '0;
    case (kind)
      K_CW: begin
        if (!m_second) begin
          m_addr = (m_addr / 256) * 256 + int'(val);
          m_second = 1'b1;
        end else begin
          m_addr = (int'(val) % 64) * 256 + (m_addr % 256);
          m_code = val[7:6];
          m_second = 1'b0;
          if (m_code == 2'd2) begin
            exp_rw = 1;
            exp_ra = val[3:0];
            exp_rd = 8'(m_addr % 256);
          end
          if (m_code == 2'd0) exp_pf = 1;
        end
      end
      K_CR: begin
        m_second = 1'b0;
        m_cpu_do = val;
        exp_sa = 1;
      end
      K_DW: begin
        m_second = 1'b0;
        if (m_code == 2'd3) begin
          exp_cw = 1;
          exp_ca = 6'(m_addr % 64);
        end else begin
          exp_vw = 1;
          exp_va = 14'(m_addr);
          ref_mem[m_addr] = val;
        end
        m_rbuf = val;
        m_addr = (m_addr + 1) % 16384;
      end
      default: begin
        m_second = 1'b0;
        m_cpu_do = m_rbuf;
        exp_pf = 1;
      end
    endcase
    $display("[%0t] op kind=%0d val=0x%02h model_addr=0x%04h", $time, kind, val, m_addr);
    strobe(kind, val);
    check_eq("vram_we", bus.vram_we, exp_vw);
    check_eq("cram_we", bus.cram_we, exp_cw);
    check_eq("reg_we", bus.reg_we, exp_rw);
    check_eq("status_ack", bus.status_ack, exp_sa);
    check_eq("cpu_do", bus.cpu_do, m_cpu_do);
    if (exp_vw) begin
      check_eq("vram_a_wr", bus.vram_a, exp_va);
      check_eq("vram_d", bus.vram_d, val);
    end
    if (exp_cw) begin
      check_eq("cram_a", bus.cram_a, exp_ca);
      check_eq("cram_d", bus.cram_d, val);
    end
    if (exp_rw) begin
      check_eq("reg_a", bus.reg_a, exp_ra);
      check_eq("reg_d", bus.reg_d, exp_rd);
    end
    check_eq("busy_start", bus.busy, exp_pf);
    if (exp_pf) begin
      pf_addr = m_addr;
      check_eq("vram_re_on", bus.vram_re, 1);
      check_eq("vram_a_rd", bus.vram_a, pf_addr);
      step();
      check_eq("busy_second", bus.busy, 1);
      check_eq("vram_re_off", bus.vram_re, 0);
      m_rbuf = ref_mem[pf_addr];
      m_addr = (pf_addr + 1) % 16384;
      step();
      check_eq("busy_end", bus.busy, 0);
    end else begin
      step();
      check_eq("pulse_width",
               {bus.vram_we, bus.cram_we, bus.reg_we, bus.status_ack, bus.vram_re}, 0);
    end
    check_eq("cpu_do_hold", bus.cpu_do, m_cpu_do);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.ctrl_wr = 1'b0; bus.ctrl_rd = 1'b0; bus.data_wr = 1'b0; bus.data_rd = 1'b0;
    bus.cpu_di = 8'h00; bus.status_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_cpu_do", bus.cpu_do, 0);
    check_eq("rst_vram_a", bus.vram_a, 0);
    check_eq("rst_outs", {bus.vram_d, bus.cram_a, bus.cram_d, bus.reg_a, bus.reg_d}, 0);
    check_eq("rst_pulses",
             {bus.vram_we, bus.cram_we, bus.reg_we, bus.status_ack, bus.vram_re}, 0);
    rst_n = 1'b1;

    // Address set with code 1, then a VRAM write
    do_op(K_CW, 8'h34); do_op(K_CW, 8'h52); do_op(K_DW, 8'hAB);
    // Register write
    do_op(K_CW, 8'h0F); do_op(K_CW, 8'h87);
    // Read prefetch
    do_op(K_CW, 8'h00); do_op(K_CW, 8'h01);
    do_op(K_DR, 8'h00);
    check_eq("prefetch_rd1", bus.cpu_do, 8'h11);
    do_op(K_DR, 8'h00);
    check_eq("prefetch_rd2", bus.cpu_do, 8'h22);
    // CRAM write at 0x3FFF then wrap to 0x0000
    do_op(K_CW, 8'hFF); do_op(K_CW, 8'hFF);
    do_op(K_DW, 8'h5A); do_op(K_DW, 8'hC3);
    // Status read clears the second-byte flag
    do_op(K_CW, 8'h10);
    do_op(K_CR, 8'h80);
    check_eq("status_cpu_do", bus.cpu_do, 8'h80);
    do_op(K_CW, 8'h20); do_op(K_CW, 8'h40); do_op(K_DW, 8'h77);

    // Strobe during busy is ignored; reset in RD_DATA aborts the prefetch
    do_op(K_CW, 8'h00);
    strobe(K_CW, 8'h05);
    check_eq("busy_rd_addr", bus.busy, 1);
    bus.data_wr = 1'b1;
    bus.cpu_di = 8'hEE;
    @(negedge clk);
    bus.data_wr = 1'b0;
    check_eq("ignored_wr", bus.vram_we, 0);
    check_eq("busy_rd_data", bus.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", bus.busy, 0);
    check_eq("async_rst_cpu_do", bus.cpu_do, 0);
    check_eq("async_rst_vram_a", bus.vram_a, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(K_DR, 8'h00);
    check_eq("rst_rbuf_zero", bus.cpu_do, 8'h00);

    // Random operations
    for (int n = 0; n < 250; n++) begin
      do_op(int'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vdp_cpu_port.md
VDP_CPU_PORT -- requirements
Module: vdp_cpu_port

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- ctrl_wr  in  1  one-cycle strobe: cpu_di written to control port
- ctrl_rd  in  1  one-cycle strobe: status read
- data_wr  in  1  one-cycle strobe: cpu_di written to data port
- data_rd  in  1  one-cycle strobe: data port read
- cpu_di  in  8  CPU write data
- cpu_do  out  8  CPU read data, registered
- status_in  in  8  status byte from interrupt/collision logic
- status_ack  out  1  one-cycle pulse: status byte was read
- busy  out  1  prefetch in progress; CPU-side adapter holds strobes while high
- vram_a  out  14  VRAM address
- vram_re  out  1  VRAM read enable
- vram_q  in  8  VRAM read data, valid one cycle after vram_re
- vram_we  out  1  VRAM write enable
- vram_d  out  8  VRAM write data
- cram_a  out  6  CRAM byte address
- cram_we  out  1  CRAM write enable
- cram_d  out  8  CRAM write data
- reg_we  out  1  VDP register write enable
- reg_a  out  4  VDP register index
- reg_d  out  8  VDP register data

REQ-002 SHALL treat at most one strobe as asserted per cycle; simultaneous strobes are undefined.

Function
REQ-003 SHALL hold these internal registers: addr[13:0], code[1:0], second-byte flag, read_buf[7:0], and a prefetch FSM with states IDLE, RD_ADDR, RD_DATA.
REQ-004 SHALL drive busy high exactly when the FSM is not in IDLE.
REQ-005 SHALL ignore every strobe that arrives while busy is high: no state change and no output pulse.
REQ-006 On ctrl_wr with the flag clear, SHALL load addr[7:0] with cpu_di and set the flag.
REQ-007 On ctrl_wr with the flag set, SHALL load addr[13:8] with cpu_di[5:0] and code with cpu_di[7:6], then clear the flag.
REQ-008 On that second ctrl_wr with code 0, SHALL start a prefetch by entering RD_ADDR on the next edge.
REQ-009 On that second ctrl_wr with code 2, SHALL pulse reg_we for one cycle, with reg_a = cpu_di[3:0] and reg_d = addr[7:0] as previously latched.
REQ-010 Prefetch sequence:
- RD_ADDR: drive vram_a = addr and vram_re = 1 for one cycle.
- RD_DATA: capture vram_q into read_buf, increment addr, return to IDLE.
- busy SHALL be high for exactly 2 cycles.
REQ-011 On data_wr, SHALL clear the flag, load read_buf with cpu_di, and increment addr.
REQ-012 On the cycle after data_wr, SHALL pulse exactly one write enable, using the pre-increment address:
- code 0, 1 or 2: vram_we, with vram_a = addr and vram_d = cpu_di.
- code 3: cram_we, with cram_a = addr[5:0] and cram_d = cpu_di.
REQ-013 On data_rd, SHALL clear the flag, register cpu_do = read_buf on the next cycle, then start a prefetch.
REQ-014 On ctrl_rd, SHALL clear the flag, register cpu_do = status_in on the next cycle, and pulse status_ack for one cycle.
REQ-015 SHALL increment addr modulo 2^14, so 0x3FFF wraps to 0x0000.
REQ-016 SHALL never hold vram_we, cram_we, reg_we, vram_re or status_ack high for more than one consecutive cycle.
REQ-017 SHALL keep cpu_do stable until the next accepted read strobe.

Reset
REQ-018 While rst_n = 0, regardless of clk, SHALL force:
- addr, code, read_buf, cpu_do, vram_a, vram_d, cram_a, cram_d, reg_a and reg_d to 0
- the flag clear and the FSM in IDLE
- busy and all enable/pulse outputs low
REQ-019 A reset asserted during a prefetch SHALL abort it, with no read_buf update and no addr increment.

Verification
REQ-020 Address and register write: ctrl_wr 0x34, then ctrl_wr 0x52 (code 1, addr 0x1234), then data_wr 0xAB -> one-cycle vram_we with vram_a = 0x1234 and vram_d = 0xAB; addr becomes 0x1235.
REQ-021 Register write: ctrl_wr 0x0F, then ctrl_wr 0x87 -> one reg_we pulse with reg_a = 7 and reg_d = 0x0F; no VRAM or CRAM activity.
REQ-022 Read prefetch: VRAM[0x0100] = 0x11 and VRAM[0x0101] = 0x22; ctrl_wr 0x00, then ctrl_wr 0x01 -> busy for 2 cycles; data_rd -> cpu_do = 0x11; after busy drops, data_rd -> cpu_do = 0x22; addr ends at 0x0103.
REQ-023 CRAM write and wrap: set code 3 with addr 0x3FFF; data_wr 0x5A -> cram_we with cram_a = 0x3F and cram_d = 0x5A; addr wraps to 0x0000; no vram_we.
REQ-024 Flag clear: ctrl_wr 0x10, then ctrl_rd with status_in = 0x80 -> cpu_do = 0x80 and one status_ack pulse; a following ctrl_wr 0x20 is treated as a first byte, so addr[7:0] = 0x20.
REQ-025 Busy and reset: a data_wr during busy is ignored (no vram_we); rst_n driven low in RD_DATA -> immediately busy = 0 and addr = 0, and read_buf stays 0 after release.
